// File: rtl/mem_axi_rd_responder.sv
// AXI read-channel memory model: queues AR requests and returns 64-bit bursts
// after a fixed latency, with R backpressure and a backdoor preload port.
module mem_axi_rd_responder #(
  parameter int unsigned ID_WIDTH      = 4,
  parameter int unsigned WORD_AW       = 12,
  parameter int unsigned RD_LATENCY    = 4,
  parameter int unsigned AR_FIFO_DEPTH = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ID_WIDTH-1:0] arid_i,
  input  logic [31:0]         araddr_i,
  input  logic [3:0]          arlen_i,
  input  logic [2:0]          arsize_i,
  input  logic [1:0]          arburst_i,
  input  logic                arvalid_i,
  output logic                arready_o,
  output logic [ID_WIDTH-1:0] rid_o,
  output logic [63:0]         rdata_o,
  output logic [1:0]          rresp_o,
  output logic                rlast_o,
  output logic                rvalid_o,
  input  logic                rready_i,
  input  logic                bd_wren_i,
  input  logic [WORD_AW-1:0]  bd_waddr_i,
  input  logic [63:0]         bd_wdata_i
);

  localparam int unsigned PTR_W       = (AR_FIFO_DEPTH > 1) ? $clog2(AR_FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W       = $clog2(AR_FIFO_DEPTH + 1);
  localparam int unsigned DEPTH_WORDS = 1 << WORD_AW;
  localparam bit          LAT1        = (RD_LATENCY == 1);

  typedef struct packed {
    logic [ID_WIDTH-1:0] id;
    logic [31:0]         addr;
    logic [3:0]          len;
    logic [2:0]          size;
    logic [1:0]          burst;
  } ar_t;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_BURST} state_t;

  function automatic logic [1:0] classify(input ar_t r);
    logic slv;
    slv = (r.size != 3'd3) || (r.burst == 2'd3) ||
          ((r.burst == 2'd2) && !(r.len inside {4'd1, 4'd3, 4'd7, 4'd15}));
    if (slv) return 2'd2;
    if ((r.addr >> (WORD_AW + 3)) != 32'd0) return 2'd3;
    return 2'd0;
  endfunction

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (32'(p) == AR_FIFO_DEPTH - 1) ? '0 : p + PTR_W'(1);
  endfunction

  // AR request FIFO
  ar_t              fifo_q [AR_FIFO_DEPTH];
  ar_t              ar_in;
  ar_t              head;
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ready_q;
  logic             push, pop, empty;

  assign ar_in     = {arid_i, araddr_i, arlen_i, arsize_i, arburst_i};
  assign push      = arvalid_i & ready_q;
  assign empty     = (count_q == '0);
  assign head      = fifo_q[rd_ptr_q];
  assign count_d   = count_q + CNT_W'(push) - CNT_W'(pop);
  assign arready_o = ready_q;

  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q] <= ar_in;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ready_q  <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      count_q <= count_d;
      ready_q <= (count_d != CNT_W'(AR_FIFO_DEPTH));
    end
  end

  // Backing store; never reset so preloaded contents survive rst
  logic [63:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (bd_wren_i) mem[bd_waddr_i] <= bd_wdata_i;
  end

  // Control FSM
  state_t      state_q, state_d;
  logic [3:0]  lat_q;
  logic        load_first, load_next, finish, hs;
  logic        rvalid_q, rlast_q;

  assign hs = rvalid_q & rready_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (!empty) state_d = LAT1 ? S_BURST : S_WAIT;
      S_WAIT:  if (lat_q == 4'd1) state_d = S_BURST;
      S_BURST: if (hs && rlast_q) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    pop        = 1'b0;
    load_first = 1'b0;
    load_next  = 1'b0;
    finish     = 1'b0;
    case (state_q)
      S_IDLE: begin
        pop        = !empty;
        load_first = !empty && LAT1;
      end
      S_WAIT:  load_first = (lat_q == 4'd1);
      S_BURST: begin
        load_next = hs && !rlast_q;
        finish    = hs && rlast_q;
      end
      default: ;
    endcase
  end

  // Popped request, classified once at pop
  logic [ID_WIDTH-1:0] req_id_q;
  logic [WORD_AW-1:0]  req_word_q;
  logic [3:0]          req_len_q;
  logic [1:0]          req_burst_q, req_resp_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lat_q       <= '0;
      req_id_q    <= '0;
      req_word_q  <= '0;
      req_len_q   <= '0;
      req_burst_q <= '0;
      req_resp_q  <= '0;
    end else if (pop) begin
      lat_q       <= 4'(RD_LATENCY - 1);
      req_id_q    <= head.id;
      req_word_q  <= head.addr[WORD_AW+2:3];
      req_len_q   <= head.len;
      req_burst_q <= head.burst;
      req_resp_q  <= classify(head);
    end else if (state_q == S_WAIT) begin
      lat_q <= lat_q - 4'd1;
    end
  end

  // Beat source: straight from the FIFO head only when the latency is one cycle
  logic                from_head;
  logic [ID_WIDTH-1:0] src_id;
  logic [WORD_AW-1:0]  src_word;
  logic [3:0]          src_len;
  logic [1:0]          src_burst, src_resp;

  assign from_head = (state_q == S_IDLE);
  assign src_id    = from_head ? head.id                : req_id_q;
  assign src_word  = from_head ? head.addr[WORD_AW+2:3] : req_word_q;
  assign src_len   = from_head ? head.len               : req_len_q;
  assign src_burst = from_head ? head.burst             : req_burst_q;
  assign src_resp  = from_head ? classify(head)         : req_resp_q;

  logic [ID_WIDTH-1:0] rid_q;
  logic [63:0]         rdata_q;
  logic [1:0]          rresp_q, burst_q;
  logic [3:0]          beat_q, len_q;
  logic [WORD_AW-1:0]  cur_q, next_word, mask, rd_word;

  assign mask = WORD_AW'(len_q);

  always_comb begin
    case (burst_q)
      2'd0:    next_word = cur_q;
      2'd2:    next_word = (cur_q & ~mask) | ((cur_q + WORD_AW'(1)) & mask);
      default: next_word = cur_q + WORD_AW'(1);
    endcase
  end

  assign rd_word = load_first ? src_word : next_word;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rvalid_q <= 1'b0;
      rlast_q  <= 1'b0;
      rdata_q  <= '0;
      rid_q    <= '0;
      rresp_q  <= '0;
      beat_q   <= '0;
      len_q    <= '0;
      burst_q  <= '0;
      cur_q    <= '0;
    end else if (load_first) begin
      rvalid_q <= 1'b1;
      rid_q    <= src_id;
      rresp_q  <= src_resp;
      rdata_q  <= (src_resp != 2'd0) ? 64'd0 : mem[rd_word];
      rlast_q  <= (src_len == 4'd0);
      beat_q   <= '0;
      len_q    <= src_len;
      burst_q  <= src_burst;
      cur_q    <= src_word;
    end else if (load_next) begin
      rdata_q  <= (rresp_q != 2'd0) ? 64'd0 : mem[rd_word];
      rlast_q  <= ((beat_q + 4'd1) == len_q);
      beat_q   <= beat_q + 4'd1;
      cur_q    <= next_word;
    end else if (finish) begin
      rvalid_q <= 1'b0;
      rlast_q  <= 1'b0;
    end
  end

  assign rvalid_o = rvalid_q;
  assign rlast_o  = rlast_q;
  assign rdata_o  = rdata_q;
  assign rid_o    = rid_q;
  assign rresp_o  = rresp_q;

endmodule

// File: tb/tb_mem_axi_rd_responder.sv
// Directed bench for mem_axi_rd_responder: bursts, backpressure, FIFO full,
// error responses, backdoor writes and mid-burst reset.
module tb_mem_axi_rd_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  arid = '0;
  logic [31:0] araddr = '0;
  logic [3:0]  arlen = '0;
  logic [2:0]  arsize = '0;
  logic [1:0]  arburst = '0;
  logic        arvalid = 1'b0;
  logic        arready;
  logic [3:0]  rid;
  logic [63:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready = 1'b0;
  logic        bd_wren = 1'b0;
  logic [11:0] bd_waddr = '0;
  logic [63:0] bd_wdata = '0;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [3:0]  id;
    logic [63:0] data;
    logic [1:0]  resp;
    logic        last;
  } beat_t;

  beat_t mon_q[$];

  mem_axi_rd_responder dut (
    .clk(clk), .rst(rst),
    .arid_i(arid), .araddr_i(araddr), .arlen_i(arlen), .arsize_i(arsize),
    .arburst_i(arburst), .arvalid_i(arvalid), .arready_o(arready),
    .rid_o(rid), .rdata_o(rdata), .rresp_o(rresp), .rlast_o(rlast),
    .rvalid_o(rvalid), .rready_i(rready),
    .bd_wren_i(bd_wren), .bd_waddr_i(bd_waddr), .bd_wdata_i(bd_wdata)
  );

  always #5 clk = ~clk;

  // Records every R handshake; inputs only change just after posedge
  always @(negedge clk) begin
    if (!rst && rvalid && rready) mon_q.push_back({rid, rdata, rresp, rlast});
  end

  function automatic beat_t mk(input logic [3:0] id, input logic [63:0] d,
                               input logic [1:0] r, input logic l);
    return {id, d, r, l};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send_ar(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                         input logic [2:0] size, input logic [1:0] burst, output int waits);
    arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst; arvalid = 1'b1;
    waits = 0;
    while (!arready && waits < 200) begin
      tick();
      waits++;
    end
    if (!arready) begin
      total++; bad++;
      $display("FAIL ar_accept id=%0d: arready stayed 0, required 1", id);
    end
    tick();
    arvalid = 1'b0;
  endtask

  task automatic wait_beats(input int n);
    int c = 0;
    while (mon_q.size() < n && c < 400) begin
      tick();
      c++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    for (int k = 0; k < 64; k++) begin
      bd_wren = 1'b1; bd_waddr = 12'(k); bd_wdata = 64'h1000 + 64'(k);
      tick();
    end
    bd_wren = 1'b0;
    total++; if (arready !== 1'b0) begin bad++; $display("FAIL rst_arready: got %b want 0", arready); end
    total++; if (rvalid !== 1'b0) begin bad++; $display("FAIL rst_rvalid: got %b want 0", rvalid); end
    total++; if (rlast !== 1'b0) begin bad++; $display("FAIL rst_rlast: got %b want 0", rlast); end
    total++; if (rdata !== 64'd0) begin bad++; $display("FAIL rst_rdata: got %h want 0", rdata); end
    total++; if (rid !== 4'd0) begin bad++; $display("FAIL rst_rid: got %h want 0", rid); end
    total++; if (rresp !== 2'd0) begin bad++; $display("FAIL rst_rresp: got %h want 0", rresp); end
    rst = 1'b0;
    tick();
    total++; if (arready !== 1'b1) begin bad++; $display("FAIL post_rst_arready: got %b want 1", arready); end
  endtask

  task automatic test_incr;
    int w, lat;
    beat_t exp_b [4];
    mon_q.delete();
    rready = 1'b1;
    send_ar(4'd5, 32'h40, 4'd3, 3'd3, 2'd1, w);
    lat = 0;
    while (!rvalid && lat < 20) begin
      tick();
      lat++;
    end
    total++; if (lat !== 4) begin bad++; $display("FAIL incr_latency: got %0d want 4", lat); end
    tick();
    total++; if (rdata !== 64'h1009) begin bad++; $display("FAIL incr_beat2: got %h want 1009", rdata); end
    rready = 1'b0;
    for (int s = 0; s < 3; s++) begin
      tick();
      total++;
      if (rvalid !== 1'b1 || rdata !== 64'h1009 || rlast !== 1'b0) begin
        bad++;
        $display("FAIL incr_stall%0d: got v=%b d=%h l=%b want v=1 d=1009 l=0", s, rvalid, rdata, rlast);
      end
    end
    rready = 1'b1;
    wait_beats(4);
    total++; if (rvalid !== 1'b0) begin bad++; $display("FAIL incr_rvalid_drop: got %b want 0", rvalid); end
    for (int i = 0; i < 4; i++) exp_b[i] = mk(4'd5, 64'h1008 + 64'(i), 2'd0, i == 3);
    total++;
    if (mon_q.size() != 4) begin
      bad++; $display("FAIL incr_count: got %0d want 4", mon_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        total++;
        if (mon_q[i] !== exp_b[i]) begin bad++; $display("FAIL incr_beat%0d: got %h want %h", i, mon_q[i], exp_b[i]); end
      end
    end
  endtask

  task automatic test_wrap;
    int w;
    int unsigned order [8] = '{5, 6, 7, 0, 1, 2, 3, 4};
    beat_t exp_b;
    mon_q.delete();
    send_ar(4'd2, 32'h28, 4'd7, 3'd3, 2'd2, w);
    wait_beats(8);
    total++;
    if (mon_q.size() != 8) begin
      bad++; $display("FAIL wrap_count: got %0d want 8", mon_q.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        exp_b = mk(4'd2, 64'h1000 + 64'(order[i]), 2'd0, i == 7);
        total++;
        if (mon_q[i] !== exp_b) begin bad++; $display("FAIL wrap_beat%0d: got %h want %h", i, mon_q[i], exp_b); end
      end
    end
  endtask

  task automatic test_fifo_full;
    int wa, wb, wc, wd;
    beat_t exp_b [9];
    mon_q.delete();
    send_ar(4'd1, 32'h0,   4'd3, 3'd3, 2'd1, wa);
    send_ar(4'd2, 32'h80,  4'd1, 3'd3, 2'd0, wb);
    send_ar(4'd3, 32'h18,  4'd0, 3'd3, 2'd1, wc);
    total++; if (arready !== 1'b0) begin bad++; $display("FAIL fifo_full_arready: got %b want 0", arready); end
    send_ar(4'd4, 32'h100, 4'd1, 3'd3, 2'd1, wd);
    total++; if (wa != 0 || wb != 0 || wc != 0) begin bad++; $display("FAIL fifo_b2b_waits: got %0d/%0d/%0d want 0/0/0", wa, wb, wc); end
    total++; if (wd != 7) begin bad++; $display("FAIL fifo_full_wait: got %0d want 7", wd); end
    wait_beats(9);
    for (int i = 0; i < 4; i++) exp_b[i] = mk(4'd1, 64'h1000 + 64'(i), 2'd0, i == 3);
    exp_b[4] = mk(4'd2, 64'h1010, 2'd0, 1'b0);
    exp_b[5] = mk(4'd2, 64'h1010, 2'd0, 1'b1);
    exp_b[6] = mk(4'd3, 64'h1003, 2'd0, 1'b1);
    exp_b[7] = mk(4'd4, 64'h1020, 2'd0, 1'b0);
    exp_b[8] = mk(4'd4, 64'h1021, 2'd0, 1'b1);
    total++;
    if (mon_q.size() != 9) begin
      bad++; $display("FAIL fifo_count: got %0d want 9", mon_q.size());
    end else begin
      for (int i = 0; i < 9; i++) begin
        total++;
        if (mon_q[i] !== exp_b[i]) begin bad++; $display("FAIL fifo_beat%0d: got %h want %h", i, mon_q[i], exp_b[i]); end
      end
    end
  endtask

  task automatic test_errors;
    int w;
    beat_t exp_b [8];
    mon_q.delete();
    send_ar(4'd6, 32'h40,        4'd3, 3'd2, 2'd1, w);
    send_ar(4'd7, 32'h28,        4'd2, 3'd3, 2'd2, w);
    send_ar(4'd8, 32'h0010_0000, 4'd0, 3'd3, 2'd1, w);
    wait_beats(8);
    for (int i = 0; i < 4; i++) exp_b[i] = mk(4'd6, 64'd0, 2'd2, i == 3);
    for (int i = 0; i < 3; i++) exp_b[4 + i] = mk(4'd7, 64'd0, 2'd2, i == 2);
    exp_b[7] = mk(4'd8, 64'd0, 2'd3, 1'b1);
    total++;
    if (mon_q.size() != 8) begin
      bad++; $display("FAIL err_count: got %0d want 8", mon_q.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        total++;
        if (mon_q[i] !== exp_b[i]) begin bad++; $display("FAIL err_beat%0d: got %h want %h", i, mon_q[i], exp_b[i]); end
      end
    end
  endtask

  task automatic test_backdoor;
    int w;
    beat_t exp_b;
    mon_q.delete();
    bd_wren = 1'b1; bd_waddr = 12'd40; bd_wdata = 64'hDEAD_BEEF_0000_0028;
    tick();
    bd_wren = 1'b0;
    send_ar(4'd12, 32'h140, 4'd0, 3'd3, 2'd1, w);
    wait_beats(1);
    exp_b = mk(4'd12, 64'hDEAD_BEEF_0000_0028, 2'd0, 1'b1);
    total++;
    if (mon_q.size() != 1) begin
      bad++; $display("FAIL bd_count: got %0d want 1", mon_q.size());
    end else if (mon_q[0] !== exp_b) begin
      bad++; $display("FAIL bd_beat: got %h want %h", mon_q[0], exp_b);
    end
  endtask

  task automatic test_reset_midburst;
    int w, c, seen;
    beat_t exp_b [2];
    rready = 1'b1;
    send_ar(4'd9,  32'h0,  4'd7, 3'd3, 2'd1, w);
    send_ar(4'd10, 32'h40, 4'd1, 3'd3, 2'd1, w);
    c = 0;
    while (!rvalid && c < 20) begin
      tick();
      c++;
    end
    tick();
    tick();
    total++; if (rdata !== 64'h1002) begin bad++; $display("FAIL rstm_beat2: got %h want 1002", rdata); end
    rst = 1'b1;
    #1;
    total++; if (rvalid !== 1'b0) begin bad++; $display("FAIL rstm_rvalid: got %b want 0", rvalid); end
    total++; if (arready !== 1'b0) begin bad++; $display("FAIL rstm_arready: got %b want 0", arready); end
    tick();
    tick();
    rst = 1'b0;
    mon_q.delete();
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (rvalid) seen++;
    end
    total++; if (seen != 0 || mon_q.size() != 0) begin bad++; $display("FAIL rstm_quiet: got %0d valid cycles want 0", seen); end
    send_ar(4'd11, 32'h10, 4'd1, 3'd3, 2'd1, w);
    wait_beats(2);
    exp_b[0] = mk(4'd11, 64'h1002, 2'd0, 1'b0);
    exp_b[1] = mk(4'd11, 64'h1003, 2'd0, 1'b1);
    total++;
    if (mon_q.size() != 2) begin
      bad++; $display("FAIL rstm_count: got %0d want 2", mon_q.size());
    end else begin
      for (int i = 0; i < 2; i++) begin
        total++;
        if (mon_q[i] !== exp_b[i]) begin bad++; $display("FAIL rstm_beat%0d: got %h want %h", i, mon_q[i], exp_b[i]); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_incr();
    test_wrap();
    test_fifo_full();
    test_errors();
    test_backdoor();
    test_reset_midburst();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
